stream_packetizer: RTL
======================

STREAM_PACKETIZER -- requirements
Module: stream_packetizer

Interface
REQ-001 Parameter SOURCE_ADDR, 8'h10, address placed in packet Source field.
REQ-002 Parameter DEST_ADDR, 8'h00, address placed in packet Destination field.
REQ-003 Parameter PACKET_WORDS, 8, 16-bit words per packet; legal range 1..127.
REQ-004 Parameter DEPTH, 32, word buffer depth; power of two and >= PACKET_WORDS.
REQ-005 ipClk  input  1  single clock; all state changes on rising edge.
REQ-006 ipReset  input  1  asynchronous, active-low reset.
REQ-007 ipData  input  16  sample word to transmit.
REQ-008 ipValid  input  1  ipData is valid this cycle; there is no backpressure.
REQ-009 ipTxReady  input  1  downstream UART transmitter accepts the presented byte this cycle.
REQ-010 opTxStream  output  UART_PACKET  byte stream: Valid, SoP, EoP, Source, Destination, Length, Data.
REQ-011 opFIFO_Size  output  log2(DEPTH)+1  words currently buffered.
REQ-012 opOverflow  output  1  one-cycle pulse when an input word is dropped.

Function
REQ-013 The block SHALL write ipData into the buffer on every cycle where ipValid=1 and the buffer is not full.
REQ-014 When ipValid=1 and the buffer is full, the block SHALL drop the word, pulse opOverflow for 1 cycle, and leave buffer contents unchanged.
REQ-015 A simultaneous write and internal pop on a full buffer SHALL accept the write, with no overflow.
REQ-016 FSM states SHALL be Idle, SendLow, SendHigh.
REQ-017 Idle -> SendLow SHALL occur when opFIFO_Size >= PACKET_WORDS; the word count is latched at that transition.
REQ-018 Each word SHALL be sent as two bytes: the lower byte [7:0] from SendLow, then the upper byte [15:8] from SendHigh.
REQ-019 A byte SHALL be presented with opTxStream.Valid=1 and SHALL be held stable until ipTxReady=1.
REQ-020 A byte SHALL count as transferred only on a cycle where Valid=1 and ipTxReady=1.
REQ-021 The word SHALL be popped from the buffer in the cycle its upper byte transfers.
REQ-022 SendHigh SHALL return to SendLow until PACKET_WORDS words have been sent, then go to Idle.
REQ-023 SoP SHALL be 1 only on the first byte of a packet; EoP SHALL be 1 only on the last byte.
REQ-024 Source, Destination and Length SHALL be driven constant for the whole packet, with Length = 2*PACKET_WORDS (8 bits).
REQ-025 Valid SHALL be 0 in Idle, and at least one idle cycle SHALL separate packets.
REQ-026 Latency SHALL be: threshold reached at edge N -> first byte Valid at edge N+1.
REQ-027 Back-to-back handshakes with ipTxReady held high SHALL transfer one byte per cycle.
REQ-028 Input writes SHALL continue uninterrupted during packet transmission.
REQ-029 opFIFO_Size SHALL reflect all writes and pops registered at the previous edge.
REQ-030 Buffer read and write pointers SHALL wrap modulo DEPTH.

Reset
REQ-031 While ipReset=0, the FSM SHALL be Idle, pointers and count 0, opTxStream all fields 0, opOverflow=0.
REQ-032 Reset asserted mid-packet SHALL abort the packet immediately: no EoP is emitted and buffered data is discarded.
REQ-033 After reset deassertion, the first accepted ipValid SHALL occur no earlier than the next rising edge.

Verification
REQ-034 Write 8 words 16'h0100..16'h0107 with ipTxReady=1 -> 16 consecutive bytes 00,01,01,01,...,07,01; SoP on byte 1, EoP on byte 16, Length=16, Destination=8'h00, Source=8'h10.
REQ-035 Same stimulus with ipTxReady toggled 1/0 each cycle -> identical byte sequence, each byte held stable while ipTxReady=0.
REQ-036 Write 7 words -> Valid stays 0; write an 8th -> packet starts next cycle.
REQ-037 Hold ipTxReady=0 and write 33 words -> opFIFO_Size=32, one opOverflow pulse, and the 33rd word never appears.
REQ-038 Write 16 words continuously with ipTxReady=1 -> two packets separated by >=1 Valid=0 cycle, data in order.
REQ-039 Assert ipReset=0 at byte 5 of a packet -> Valid=0 and opFIFO_Size=0 immediately; after release, 8 new words produce a clean packet starting with SoP.

Source files
------------

// File: rtl/stream_packetizer.sv
// stream_packetizer
//   Buffers 16-bit sample words and emits them as fixed-length byte packets
//   towards a UART transmitter. Each word leaves as two bytes: the low byte
//   first, then the high byte. Packet header fields (Source, Destination,
//   Length) ride alongside every byte of the packet.
//
// Ports
//   ipClk        single clock, rising edge
//   ipReset      asynchronous, active-low reset
//   ipData       sample word
//   ipValid      ipData valid this cycle (no backpressure)
//   ipTxReady    downstream accepts the presented byte this cycle
//   opTxStream   byte stream with framing and header fields
//   opFIFO_Size  words currently buffered
//   opOverflow   one-cycle pulse when an input word was dropped

package stream_packetizer_pkg;
  typedef struct packed {
    logic       Valid;
    logic       SoP;
    logic       EoP;
    logic [7:0] Source;
    logic [7:0] Destination;
    logic [7:0] Length;
    logic [7:0] Data;
  } UART_PACKET;
endpackage

module stream_packetizer
  import stream_packetizer_pkg::*;
#(
  parameter logic [7:0]  SOURCE_ADDR  = 8'h10,
  parameter logic [7:0]  DEST_ADDR    = 8'h00,
  parameter int unsigned PACKET_WORDS = 8,
  parameter int unsigned DEPTH        = 32
) (
  input  logic                     ipClk,
  input  logic                     ipReset,
  input  logic [15:0]              ipData,
  input  logic                     ipValid,
  input  logic                     ipTxReady,
  output UART_PACKET               opTxStream,
  output logic [$clog2(DEPTH):0]   opFIFO_Size,
  output logic                     opOverflow
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CW   = AW + 1;
  localparam int unsigned PTRW = (AW == 0) ? 1 : AW;

  localparam logic [CW-1:0]   CNT_FULL  = CW'(DEPTH);
  localparam logic [CW-1:0]   CNT_PKT   = CW'(PACKET_WORDS);
  localparam logic [PTRW-1:0] PTR_LAST  = PTRW'(DEPTH - 1);
  localparam logic [6:0]      LAST_WORD = 7'(PACKET_WORDS - 1);
  localparam logic [7:0]      PKT_LEN   = 8'(2 * PACKET_WORDS);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_SEND_LOW  = 2'd1;
  localparam logic [1:0] ST_SEND_HIGH = 2'd2;

  logic [15:0]     mem [DEPTH];
  logic [PTRW-1:0] wrPtr;
  logic [PTRW-1:0] rdPtr;
  logic [CW-1:0]   count;
  logic [1:0]      state;
  logic [6:0]      wordCnt;

  logic        full;
  logic        pop;
  logic        wrEn;
  logic        drop;
  logic        lastWord;
  logic [15:0] rdWord;

  always_comb begin
    full     = (count == CNT_FULL);
    pop      = (state == ST_SEND_HIGH) && ipTxReady;
    // A pop in the same cycle frees the slot, so a full buffer still accepts.
    wrEn     = ipValid && (!full || pop);
    drop     = ipValid && full && !pop;
    lastWord = (wordCnt == LAST_WORD);
    rdWord   = mem[rdPtr];
  end

  // Storage carries no reset; discarding data on reset is done by the pointers.
  always_ff @(posedge ipClk) begin
    if (wrEn) begin
      mem[wrPtr] <= ipData;
    end
  end

  always_ff @(posedge ipClk or negedge ipReset) begin
    if (!ipReset) begin
      wrPtr      <= '0;
      rdPtr      <= '0;
      count      <= '0;
      opOverflow <= 1'b0;
    end else begin
      opOverflow <= drop;
      if (wrEn) begin
        wrPtr <= (wrPtr == PTR_LAST) ? '0 : wrPtr + 1'b1;
      end
      if (pop) begin
        rdPtr <= (rdPtr == PTR_LAST) ? '0 : rdPtr + 1'b1;
      end
      case ({wrEn, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge ipClk or negedge ipReset) begin
    if (!ipReset) begin
      state   <= ST_IDLE;
      wordCnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (count >= CNT_PKT) begin
            state   <= ST_SEND_LOW;
            wordCnt <= '0;
          end
        end
        ST_SEND_LOW: begin
          if (ipTxReady) begin
            state <= ST_SEND_HIGH;
          end
        end
        ST_SEND_HIGH: begin
          if (ipTxReady) begin
            if (lastWord) begin
              state <= ST_IDLE;
            end else begin
              state   <= ST_SEND_LOW;
              wordCnt <= wordCnt + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Byte fields decode straight from registered state and the buffer head;
  // the head word cannot change until its high byte is accepted, so the
  // presented byte stays stable while the transmitter stalls.
  always_comb begin
    opTxStream = '0;
    if (state != ST_IDLE) begin
      opTxStream.Valid       = 1'b1;
      opTxStream.SoP         = (state == ST_SEND_LOW) && (wordCnt == '0);
      opTxStream.EoP         = (state == ST_SEND_HIGH) && lastWord;
      opTxStream.Source      = SOURCE_ADDR;
      opTxStream.Destination = DEST_ADDR;
      opTxStream.Length      = PKT_LEN;
      opTxStream.Data        = (state == ST_SEND_HIGH) ? rdWord[15:8] : rdWord[7:0];
    end
  end

  assign opFIFO_Size = count;

endmodule
